// File: rtl/mdr_load_unit.sv
// Memory Data Register with S/M bus load, wait-state FSM for slow memory, timeout and conflict pulses.
// Optional registered even-parity output enabled by defining MDR_PARITY_EN.
module mdr_load_unit #(
  parameter int WIDTH    = 16,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] M_bus,
  input  logic [WIDTH-1:0] S_bus,
  input  logic             MMD,
  input  logic             SMD,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] MDR_out,
  output logic             busy,
  output logic             conflict,
`ifdef MDR_PARITY_EN
  output logic             MDR_parity,
`endif
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mdr_d      = mdr_q;
    conflict_d = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MMD && SMD) begin
          conflict_d = 1'b1;
        end else if (SMD) begin
          mdr_d = S_bus;
        end else if (MMD) begin
          if (mem_ready) begin
            mdr_d = M_bus;
          end else begin
            state_d = WAIT_MEM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT_MEM: begin
        // A late ready on the expiry edge still wins over the timeout.
        if (mem_ready) begin
          mdr_d   = M_bus;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(WAIT_MAX)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT_MEM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mdr_q      <= '0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mdr_q      <= mdr_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
    end
  end

  assign MDR_out  = mdr_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
  assign timeout  = timeout_q;

`ifdef MDR_PARITY_EN
  logic parity_q, parity_d;

  // Computed from the next MDR value so parity tracks every load and every hold.
  always_comb parity_d = ^mdr_d;

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign MDR_parity = parity_q;
`endif

endmodule
